// File: rtl/keyboard_pkg.sv
// Shared PS/2 keyboard definitions: prefix bytes, scan FSM states and key codes
// used by the decoder and by downstream key-driven control logic.
package keyboard_pkg;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_BRK = 8'hF0;

  localparam logic [8:0] KEY_ENTER = 9'h05A;
  localparam logic [8:0] KEY_ESC   = 9'h076;
  localparam logic [8:0] KEY_SPACE = 9'h029;
  localparam logic [8:0] KEY_UP    = 9'h175;
  localparam logic [8:0] KEY_DOWN  = 9'h172;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } scan_state_t;

  // Keyboard status/response bytes that never carry a key code.
  function automatic logic is_discard(input logic [7:0] b);
    logic r;
    case (b)
      8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFC, 8'h00, 8'hFF: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Odd parity over data byte plus parity bit.
  function automatic logic odd_parity_ok(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes and filters the keyboard lines, shifts in 11-bit
// frames on filtered falling clock edges, checks framing and drops stale partial frames.
module ps2_rx
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
  output logic       o_frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic [FW-1:0] r_filt_cnt;
  logic          r_clk_filt;
  logic          r_clk_filt_d;
  logic [3:0]    r_bit_cnt;
  logic [9:0]    r_frame;
  logic [TW-1:0] r_to_cnt;
  logic [7:0]    r_byte;
  logic          r_byte_valid;
  logic          r_frame_err;
  logic          w_fall;
  logic          w_frame_ok;

  assign w_fall     = r_clk_filt_d & ~r_clk_filt;
  assign w_frame_ok = (r_frame[0] == 1'b0) && odd_parity_ok(r_frame[9:1]) && r_data_sync[1];

  // Two-flop synchronizers, then a level filter that needs FILTER_LEN agreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync   <= 2'b11;
      r_data_sync  <= 2'b11;
      r_filt_cnt   <= '0;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
    end else begin
      r_clk_sync   <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync  <= {r_data_sync[0], i_ps2_data};
      r_clk_filt_d <= r_clk_filt;
      if (r_clk_sync[1] == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
        r_clk_filt <= r_clk_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 1'b1;
      end
    end
  end

  // Frame assembly; the 11th edge carries the stop bit and closes the frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_cnt    <= 4'd0;
      r_frame      <= 10'd0;
      r_to_cnt     <= '0;
      r_byte       <= 8'd0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (w_fall) begin
        r_to_cnt <= '0;
        if (r_bit_cnt == 4'd10) begin
          r_bit_cnt <= 4'd0;
          if (w_frame_ok) begin
            r_byte       <= r_frame[8:1];
            r_byte_valid <= 1'b1;
          end else begin
            r_frame_err <= 1'b1;
          end
        end else begin
          r_frame   <= {r_data_sync[1], r_frame[9:1]};
          r_bit_cnt <= r_bit_cnt + 4'd1;
        end
      end else if (r_bit_cnt != 4'd0) begin
        // A silent line mid-frame means the keyboard gave up; realign on the next start bit.
        if (r_to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          r_bit_cnt <= 4'd0;
          r_to_cnt  <= '0;
        end else begin
          r_to_cnt <= r_to_cnt + 1'b1;
        end
      end else begin
        r_to_cnt <= '0;
      end
    end
  end

  assign o_byte       = r_byte;
  assign o_byte_valid = r_byte_valid;
  assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: turns E0/F0-prefixed scan bytes into 9-bit key events
// and maintains the pressed-key bitmap.
module keyboard_decoder
  import keyboard_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PS2_CLK,
  input  logic         PS2_DATA,
  output logic [8:0]   last_change,
  output logic         key_valid,
  output logic [511:0] key_down,
  output logic         frame_err
);

  logic [7:0]   w_byte;
  logic         w_byte_valid;
  logic         w_frame_err;
  scan_state_t  r_state;
  scan_state_t  w_next_state;
  logic         w_emit;
  logic         w_make;
  logic [8:0]   w_code;
  logic [8:0]   r_last_change;
  logic         r_key_valid;
  logic [511:0] r_key_down;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk         (clk),
    .reset       (reset),
    .i_ps2_clk   (PS2_CLK),
    .i_ps2_data  (PS2_DATA),
    .o_byte      (w_byte),
    .o_byte_valid(w_byte_valid),
    .o_frame_err (w_frame_err)
  );

  // Scan FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Prefix tracking and key-code formation.
  always_comb begin
    w_next_state = r_state;
    w_emit       = 1'b0;
    w_make       = 1'b0;
    w_code       = {(r_state == ST_EXT) || (r_state == ST_EXT_BRK), w_byte};
    if (w_frame_err) begin
      w_next_state = ST_IDLE;
    end else if (w_byte_valid) begin
      if (w_byte == PREFIX_EXT) begin
        case (r_state)
          ST_IDLE: w_next_state = ST_EXT;
          ST_BRK:  w_next_state = ST_EXT_BRK;
          default: w_next_state = r_state;
        endcase
      end else if (w_byte == PREFIX_BRK) begin
        case (r_state)
          ST_IDLE: w_next_state = ST_BRK;
          ST_EXT:  w_next_state = ST_EXT_BRK;
          default: w_next_state = r_state;
        endcase
      end else if (is_discard(w_byte)) begin
        w_next_state = r_state;
      end else begin
        w_emit       = 1'b1;
        w_make       = (r_state == ST_IDLE) || (r_state == ST_EXT);
        w_next_state = ST_IDLE;
      end
    end else begin
      w_next_state = r_state;
    end
  end

  // Event bus registers; a repeated make simply rewrites the same bitmap value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_change <= 9'd0;
      r_key_valid   <= 1'b0;
      r_key_down    <= '0;
    end else begin
      r_key_valid <= w_emit;
      if (w_emit) begin
        r_last_change      <= w_code;
        r_key_down[w_code] <= w_make;
      end else begin
        r_last_change <= r_last_change;
      end
    end
  end

  assign last_change = r_last_change;
  assign key_valid   = r_key_valid;
  assign key_down    = r_key_down;
  assign frame_err   = w_frame_err;

endmodule
